// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle CPU controller: state encodings, opcodes, PC source codes.
// Pure declarations, no logic, no latency and no backpressure.
package cpu_ctrl_pkg;

    localparam logic [2:0] ST_IF    = 3'b000;
    localparam logic [2:0] ST_ID    = 3'b001;
    localparam logic [2:0] ST_EXE_M = 3'b010;
    localparam logic [2:0] ST_MEM   = 3'b011;
    localparam logic [2:0] ST_WB_L  = 3'b100;
    localparam logic [2:0] ST_EXE_B = 3'b101;
    localparam logic [2:0] ST_EXE_R = 3'b110;
    localparam logic [2:0] ST_WB_R  = 3'b111;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       reg_wre;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] pc_src;
        logic       alu_src_b;
        logic       wr_reg_d_src;
        logic       reg_dst;
    } ctrl_t;

endpackage

// File: rtl/state_reg.sv
// 3-bit controller state register, asynchronously cleared to IF.
// One-cycle latency from state_d_i to state_q_o, no backpressure.
module state_reg
    import cpu_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] state_d_i,
    output logic [2:0] state_q_o
);

    logic [2:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d_i;
        end
    end

    assign state_q_o = state_q;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: registered state, control outputs decoded combinationally from state/opcode/zero.
// One state per clock, no backpressure; HALT_OP parks the FSM in ID until reset.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc,
    output logic       ALUSrcB,
    output logic       WrRegDSrc,
    output logic       RegDst
);

    logic [2:0] state_d;
    logic [2:0] state_q;
    ctrl_t      ctrl;

    logic is_halt, is_rrr, is_imm, is_alu, is_lw, is_sw, is_mem;
    logic is_beq, is_bne, is_br, is_j;

    // HALT_OP takes priority so a colliding parameter value can never start an instruction.
    assign is_halt = (opcode == HALT_OP);
    assign is_rrr  = !is_halt && (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND);
    assign is_imm  = !is_halt && (opcode == OP_ADDI || opcode == OP_ORI);
    assign is_alu  = is_rrr || is_imm;
    assign is_lw   = !is_halt && (opcode == OP_LW);
    assign is_sw   = !is_halt && (opcode == OP_SW);
    assign is_mem  = is_lw || is_sw;
    assign is_beq  = !is_halt && (opcode == OP_BEQ);
    assign is_bne  = !is_halt && (opcode == OP_BNE);
    assign is_br   = is_beq || is_bne;
    assign is_j    = !is_halt && (opcode == OP_J);

    state_reg u_state_reg (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .state_d_i (state_d),
        .state_q_o (state_q)
    );

    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF:    state_d = ST_ID;
            ST_ID: begin
                if (is_halt)     state_d = ST_ID;
                else if (is_alu) state_d = ST_EXE_R;
                else if (is_mem) state_d = ST_EXE_M;
                else if (is_br)  state_d = ST_EXE_B;
                else             state_d = ST_IF;
            end
            ST_EXE_R: state_d = ST_WB_R;
            ST_WB_R:  state_d = ST_IF;
            ST_EXE_B: state_d = ST_IF;
            ST_EXE_M: state_d = ST_MEM;
            ST_MEM:   state_d = is_lw ? ST_WB_L : ST_IF;
            ST_WB_L:  state_d = ST_IF;
            default:  state_d = ST_IF;
        endcase
    end

    always_comb begin
        ctrl           = '0;
        ctrl.pc_src    = PCSRC_PC4;
        ctrl.alu_src_b = is_imm || is_mem;
        ctrl.reg_dst   = is_rrr;
        case (state_q)
            ST_IF: ctrl.ir_wre = 1'b1;
            ST_ID: begin
                // J and undefined opcodes retire here; halt holds the PC.
                ctrl.pc_wre = !is_halt && !is_alu && !is_mem && !is_br;
                if (is_j) ctrl.pc_src = PCSRC_JMP;
            end
            ST_EXE_B: begin
                ctrl.pc_wre = 1'b1;
                if ((is_beq && zero) || (is_bne && !zero)) ctrl.pc_src = PCSRC_BR;
            end
            ST_MEM: begin
                ctrl.mem_rd = is_lw;
                ctrl.mem_wr = is_sw;
                ctrl.pc_wre = is_sw;
            end
            ST_WB_R: begin
                ctrl.pc_wre  = 1'b1;
                ctrl.reg_wre = is_alu;
            end
            ST_WB_L: begin
                ctrl.pc_wre       = 1'b1;
                ctrl.reg_wre      = is_lw;
                ctrl.wr_reg_d_src = 1'b1;
            end
            default: ;
        endcase
    end

    assign state     = state_q;
    assign PCWre     = ctrl.pc_wre;
    assign IRWre     = ctrl.ir_wre;
    assign RegWre    = ctrl.reg_wre;
    assign mRD       = ctrl.mem_rd;
    assign mWR       = ctrl.mem_wr;
    assign PCSrc     = ctrl.pc_src;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign WrRegDSrc = ctrl.wr_reg_d_src;
    assign RegDst    = ctrl.reg_dst;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class through its state sequence.
// Expected values are hand-written per cycle.
module tb_multi_cycle_ctrl;

    logic       CLK;
    logic       RST;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       PCWre, IRWre, RegWre, mRD, mWR;
    logic [1:0] PCSrc;
    logic       ALUSrcB, WrRegDSrc, RegDst;

    int n_chk  = 0;
    int n_fail = 0;

    multi_cycle_ctrl #(.HALT_OP(6'b111111)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .zero      (zero),
        .state     (state),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .mRD       (mRD),
        .mWR       (mWR),
        .PCSrc     (PCSrc),
        .ALUSrcB   (ALUSrcB),
        .WrRegDSrc (WrRegDSrc),
        .RegDst    (RegDst)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [2:0] st, input logic pcw,
                           input logic irw, input logic rw, input logic rd,
                           input logic wr, input logic [1:0] src);
        chk({tag, ".state"},  state,       st);
        chk({tag, ".PCWre"},  3'(PCWre),   3'(pcw));
        chk({tag, ".IRWre"},  3'(IRWre),   3'(irw));
        chk({tag, ".RegWre"}, 3'(RegWre),  3'(rw));
        chk({tag, ".mRD"},    3'(mRD),     3'(rd));
        chk({tag, ".mWR"},    3'(mWR),     3'(wr));
        chk({tag, ".PCSrc"},  3'(PCSrc),   3'(src));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST    = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        #3;
        chk_cyc("reset", 3'b000, 0, 1, 0, 0, 0, 2'b00);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
        chk_cyc("post_reset_if", 3'b000, 0, 1, 0, 0, 0, 2'b00);

        // ADD
        opcode = 6'b000000;
        tick(); chk_cyc("add.id",  3'b001, 0, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("add.exe", 3'b110, 0, 0, 0, 0, 0, 2'b00);
        chk("add.ALUSrcB", 3'(ALUSrcB), 3'd0);
        tick(); chk_cyc("add.wb",  3'b111, 1, 0, 1, 0, 0, 2'b00);
        chk("add.RegDst", 3'(RegDst), 3'd1);
        chk("add.WrRegDSrc", 3'(WrRegDSrc), 3'd0);
        tick(); chk_cyc("add.if",  3'b000, 0, 1, 0, 0, 0, 2'b00);

        // LW
        opcode = 6'b110001;
        tick(); chk_cyc("lw.id",   3'b001, 0, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("lw.exe",  3'b010, 0, 0, 0, 0, 0, 2'b00);
        chk("lw.ALUSrcB", 3'(ALUSrcB), 3'd1);
        tick(); chk_cyc("lw.mem",  3'b011, 0, 0, 0, 1, 0, 2'b00);
        tick(); chk_cyc("lw.wb",   3'b100, 1, 0, 1, 0, 0, 2'b00);
        chk("lw.WrRegDSrc", 3'(WrRegDSrc), 3'd1);
        tick(); chk_cyc("lw.if",   3'b000, 0, 1, 0, 0, 0, 2'b00);

        // SW
        opcode = 6'b110000;
        tick(); chk_cyc("sw.id",   3'b001, 0, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("sw.exe",  3'b010, 0, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("sw.mem",  3'b011, 1, 0, 0, 0, 1, 2'b00);
        tick(); chk_cyc("sw.if",   3'b000, 0, 1, 0, 0, 0, 2'b00);

        // BEQ taken
        opcode = 6'b110100; zero = 1'b1;
        tick(); chk_cyc("beq1.id",  3'b001, 0, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("beq1.exe", 3'b101, 1, 0, 0, 0, 0, 2'b01);
        tick(); chk_cyc("beq1.if",  3'b000, 0, 1, 0, 0, 0, 2'b00);

        // BEQ not taken
        zero = 1'b0;
        tick(); chk_cyc("beq0.id",  3'b001, 0, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("beq0.exe", 3'b101, 1, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("beq0.if",  3'b000, 0, 1, 0, 0, 0, 2'b00);

        // BNE taken, then not taken
        opcode = 6'b110101; zero = 1'b0;
        tick(); chk_cyc("bne0.id",  3'b001, 0, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("bne0.exe", 3'b101, 1, 0, 0, 0, 0, 2'b01);
        zero = 1'b1;
        #1; chk("bne1.PCSrc", 3'(PCSrc), 3'd0);
        tick(); chk_cyc("bne.if",   3'b000, 0, 1, 0, 0, 0, 2'b00);

        // J
        opcode = 6'b111000; zero = 1'b0;
        tick(); chk_cyc("j.id",    3'b001, 1, 0, 0, 0, 0, 2'b10);
        tick(); chk_cyc("j.if",    3'b000, 0, 1, 0, 0, 0, 2'b00);

        // Undefined opcode
        opcode = 6'b101010;
        tick(); chk_cyc("undef.id", 3'b001, 1, 0, 0, 0, 0, 2'b00);
        tick(); chk_cyc("undef.if", 3'b000, 0, 1, 0, 0, 0, 2'b00);

        // HALT holds ID
        opcode = 6'b111111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_cyc($sformatf("halt.%0d", i), 3'b001, 0, 0, 0, 0, 0, 2'b00);
        end

        // Async reset mid-hold, well before the next edge
        #2;
        RST = 1'b0;
        #1;
        chk_cyc("halt.async_rst", 3'b000, 0, 1, 0, 0, 0, 2'b00);
        #1;
        RST = 1'b1;
        tick(); chk_cyc("rst_release.id", 3'b001, 0, 0, 0, 0, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
